// File: rtl/router_pkg.sv
// router_pkg
//   Shared types and helpers for the XY-mesh SNN router merge/forward stages.
//   - off_class_e : classification of a head word by its hop offset
//   - step_offset : moves an offset one hop closer to zero
//   - stripped_width : width of a packet once the offset field is removed
package router_pkg;

    typedef enum logic [1:0] {
        CLS_FWD,
        CLS_TURN_A,
        CLS_TURN_B,
        CLS_ERR
    } off_class_e;

    // Offsets are carried sign-extended to 32 bits; the caller truncates back
    // to the field width. A positive-direction stage decrements, a negative
    // one increments.
    function automatic logic signed [31:0] step_offset(input logic signed [31:0] off,
                                                       input logic              pos_dir);
        return pos_dir ? (off - 32'sd1) : (off + 32'sd1);
    endfunction

    function automatic int stripped_width(input int packet_width, input int off_width);
        return packet_width - off_width;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// router_fifo
//   Synchronous first-word-fall-through buffer with asynchronous active-low reset.
//   Ports:
//     clk, reset_n         clock, async active-low reset
//     wr_en, wr_data       write request/data (ignored when full)
//     rd_en                pop request (ignored when empty)
//     rd_data              head word, forced to 0 while empty
//     empty, full, count   occupancy status derived from the registered count
module router_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Full/empty come from the registered count only, so a write into a full
    // buffer stays blocked even if the head is popped in the same cycle.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/router_merge_forward.sv
// router_merge_forward
//   Merge + forward stage for one direction of the XY-mesh SNN router.
//   Round-robin merges NUM_IN FWFT sources, classifies each head by its hop
//   offset and steers it to the fwd buffer (offset stepped toward zero), a
//   turn buffer (offset field stripped) or drops it (wrong-sign offset).
//   Ports:
//     din/empty_in/ren_out            merged sources (ren_out combinational)
//     dout_fwd/empty_fwd/ren_fwd      straight-through buffer
//     dout_turn_a/b, empty_turn_a/b,
//     ren_turn_a/b                    turn buffers
//     full_any                        any output buffer full
//     pkt_count/err_count/err_pulse   accepted / dropped packet status
module router_merge_forward
    import router_pkg::*;
#(
    parameter int NUM_IN       = 3,
    parameter int PACKET_WIDTH = 30,
    parameter int OFF_MSB      = 29,
    parameter int OFF_LSB      = 21,
    parameter int TURN_SEL_BIT = 20,
    parameter bit POS_DIR      = 1'b1,
    parameter int BUFFER_DEPTH = 4,
    parameter int CNT_W        = 16
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [NUM_IN*PACKET_WIDTH-1:0]         din,
    input  logic [NUM_IN-1:0]                      empty_in,
    output logic [NUM_IN-1:0]                      ren_out,
    output logic [PACKET_WIDTH-1:0]                dout_fwd,
    output logic                                   empty_fwd,
    input  logic                                   ren_fwd,
    output logic [PACKET_WIDTH-(OFF_MSB-OFF_LSB+1)-1:0] dout_turn_a,
    output logic                                   empty_turn_a,
    input  logic                                   ren_turn_a,
    output logic [PACKET_WIDTH-(OFF_MSB-OFF_LSB+1)-1:0] dout_turn_b,
    output logic                                   empty_turn_b,
    input  logic                                   ren_turn_b,
    output logic                                   full_any,
    output logic [CNT_W-1:0]                       pkt_count,
    output logic [CNT_W-1:0]                       err_count,
    output logic                                   err_pulse
);
    localparam int OFF_W   = OFF_MSB - OFF_LSB + 1;
    localparam int STRIP_W = stripped_width(PACKET_WIDTH, OFF_W);
    localparam int PTR_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int CW      = $clog2(BUFFER_DEPTH) + 1;

    off_class_e                  cls [NUM_IN];
    logic [NUM_IN-1:0]           elig;
    logic [PTR_W-1:0]            ptr;
    logic [PTR_W-1:0]            grant_idx;
    logic                        grant_vld;
    logic [PACKET_WIDTH-1:0]     sel_word;
    off_class_e                  sel_cls;
    logic signed [OFF_W-1:0]     sel_off;
    logic signed [31:0]          stepped_off;
    logic [PACKET_WIDTH-1:0]     fwd_word;
    logic                        wr_fwd, wr_ta, wr_tb;
    logic                        full_fwd, full_ta, full_tb;
    logic [CW-1:0]               cnt_fwd, cnt_ta, cnt_tb;
    logic                        space_fwd, space_ta, space_tb;

    assign space_fwd = (cnt_fwd != CW'(BUFFER_DEPTH));
    assign space_ta  = (cnt_ta  != CW'(BUFFER_DEPTH));
    assign space_tb  = (cnt_tb  != CW'(BUFFER_DEPTH));
    assign full_any  = full_fwd || full_ta || full_tb;

    // Classify each source head and decide eligibility. Error heads are always
    // eligible so a bad packet can never block its source.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            logic signed [OFF_W-1:0] off_v;
            off_v = din[i*PACKET_WIDTH+OFF_LSB +: OFF_W];
            if (off_v == '0) begin
                cls[i] = din[i*PACKET_WIDTH+TURN_SEL_BIT] ? CLS_TURN_B : CLS_TURN_A;
            end else if (off_v[OFF_W-1] != POS_DIR) begin
                cls[i] = CLS_FWD;
            end else begin
                cls[i] = CLS_ERR;
            end
            case (cls[i])
                CLS_FWD:    elig[i] = !empty_in[i] && space_fwd;
                CLS_TURN_A: elig[i] = !empty_in[i] && space_ta;
                CLS_TURN_B: elig[i] = !empty_in[i] && space_tb;
                default:    elig[i] = !empty_in[i];
            endcase
        end
    end

    // Round-robin scan starting at ptr; first eligible source wins.
    always_comb begin
        int scan_idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            scan_idx = (int'(ptr) + k) % NUM_IN;
            if (!grant_vld && elig[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = PTR_W'(scan_idx);
            end
        end
        ren_out = '0;
        if (grant_vld && reset_n) begin
            ren_out[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_word    = din[int'(grant_idx)*PACKET_WIDTH +: PACKET_WIDTH];
        sel_cls     = cls[grant_idx];
        sel_off     = sel_word[OFF_MSB:OFF_LSB];
        stepped_off = step_offset(32'(sel_off), POS_DIR);
        fwd_word    = {stepped_off[OFF_W-1:0], sel_word[OFF_LSB-1:0]};
        wr_fwd      = grant_vld && (sel_cls == CLS_FWD);
        wr_ta       = grant_vld && (sel_cls == CLS_TURN_A);
        wr_tb       = grant_vld && (sel_cls == CLS_TURN_B);
    end

    // ---- grant edge: arbitration pointer and status counters ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            pkt_count <= '0;
            err_count <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= grant_vld && (sel_cls == CLS_ERR);
            if (grant_vld) begin
                ptr <= (grant_idx == PTR_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
                if (sel_cls == CLS_ERR) begin
                    if (err_count != '1) err_count <= err_count + 1'b1;
                end else begin
                    pkt_count <= pkt_count + 1'b1;
                end
            end
        end
    end

    router_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(BUFFER_DEPTH)) u_fifo_fwd (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_fwd), .wr_data(fwd_word),
        .rd_en(ren_fwd), .rd_data(dout_fwd), .empty(empty_fwd), .full(full_fwd),
        .count(cnt_fwd)
    );

    router_fifo #(.WIDTH(STRIP_W), .DEPTH(BUFFER_DEPTH)) u_fifo_turn_a (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_ta), .wr_data(sel_word[STRIP_W-1:0]),
        .rd_en(ren_turn_a), .rd_data(dout_turn_a), .empty(empty_turn_a), .full(full_ta),
        .count(cnt_ta)
    );

    router_fifo #(.WIDTH(STRIP_W), .DEPTH(BUFFER_DEPTH)) u_fifo_turn_b (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_tb), .wr_data(sel_word[STRIP_W-1:0]),
        .rd_en(ren_turn_b), .rd_data(dout_turn_b), .empty(empty_turn_b), .full(full_tb),
        .count(cnt_tb)
    );

endmodule
